// File: rtl/cnn_buf_loader_if.sv
// Read-request and buffer-write bundle between cnn_buf_loader (master) and the memory/buffer side (slave).
`timescale 1ns/1ps
interface cnn_buf_loader_if #(
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 64,
  parameter int W_IFM_BUF  = 2,
  parameter int W_BUF_ADDR = 11
);
  logic                  o_rd_req;
  logic [W_ADDR-1:0]     o_rd_addr;
  logic                  i_rd_valid;
  logic [W_DATA-1:0]     i_rd_data;
  logic                  o_buf_we;
  logic                  o_buf_is_filter;
  logic [W_IFM_BUF-1:0]  o_buf_sel;
  logic [W_BUF_ADDR-1:0] o_buf_addr;
  logic [W_DATA-1:0]     o_buf_wdata;

  modport master (
    output o_rd_req, o_rd_addr, o_buf_we, o_buf_is_filter, o_buf_sel, o_buf_addr, o_buf_wdata,
    input  i_rd_valid, i_rd_data
  );

  modport slave (
    input  o_rd_req, o_rd_addr, o_buf_we, o_buf_is_filter, o_buf_sel, o_buf_addr, o_buf_wdata,
    output i_rd_valid, i_rd_data
  );
endinterface

// File: rtl/cnn_buf_loader.sv
// Loads one filter tile, then IFM rows round-robin into a ring of row buffers, one read outstanding
// (1 word / 2 cycles peak, write one cycle after data); stalls in I_CHK while every row buffer is unreleased.
`timescale 1ns/1ps
module cnn_buf_loader #(
  parameter int W_SIZE      = 10,
  parameter int W_CHANNEL   = 5,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 64,
  parameter int W_BUF_ADDR  = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_start,
  input  logic [W_SIZE-1:0]      q_width,
  input  logic [W_SIZE-1:0]      q_height,
  input  logic [W_CHANNEL-1:0]   q_channel,
  input  logic [W_BUF_ADDR-1:0]  q_filter_words,
  input  logic [W_ADDR-1:0]      q_filter_base,
  input  logic [W_ADDR-1:0]      q_ifm_base,
  input  logic                   i_row_release,
  cnn_buf_loader_if.master       bus,
  output logic                   o_filter_buf_done,
  output logic [IFM_BUF_CNT-1:0] o_ifm_buf_done,
  output logic                   o_busy
);
  typedef enum logic [2:0] {S_IDLE, S_F_REQ, S_F_WAIT, S_I_CHK, S_I_REQ, S_I_WAIT, S_FINISH} state_t;

  localparam logic [W_IFM_BUF:0] OCC_FULL = IFM_BUF_CNT[W_IFM_BUF:0];

  state_t                 r_state, w_next;
  logic [W_BUF_ADDR-1:0]  r_filter_words, r_row_words, r_word_cnt;
  logic [W_ADDR-1:0]      r_filter_base, r_row_addr;
  logic [W_SIZE-1:0]      r_height, r_row_cnt;
  logic [W_IFM_BUF-1:0]   r_wr_ptr;
  logic [W_IFM_BUF:0]     r_occ;
  logic                   r_buf_we, r_buf_is_filter;
  logic [W_IFM_BUF-1:0]   r_buf_sel;
  logic [W_BUF_ADDR-1:0]  r_buf_addr;
  logic [W_DATA-1:0]      r_buf_wdata;
  logic                   r_fdone_pend, r_filter_done;
  logic [IFM_BUF_CNT-1:0] r_idone_pend, r_ifm_done;
  logic                   w_rd_req;
  logic [W_ADDR-1:0]      w_rd_addr;
  logic                   w_f_last, w_i_last, w_row_done;
  logic [W_BUF_ADDR-1:0]  w_row_words;

  assign w_row_words = W_BUF_ADDR'(q_width) * W_BUF_ADDR'(q_channel);
  assign w_f_last    = (r_word_cnt == r_filter_words - W_BUF_ADDR'(1));
  assign w_i_last    = (r_word_cnt == r_row_words - W_BUF_ADDR'(1));
  assign w_row_done  = (r_state == S_I_WAIT) && bus.i_rd_valid && w_i_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd_req  = 1'b0;
    w_rd_addr = '0;
    case (r_state)
      S_IDLE:   if (q_start) w_next = S_F_REQ;
      S_F_REQ: begin
        w_rd_req  = 1'b1;
        w_rd_addr = r_filter_base + W_ADDR'(r_word_cnt);
        w_next    = S_F_WAIT;
      end
      S_F_WAIT: if (bus.i_rd_valid) w_next = w_f_last ? S_I_CHK : S_F_REQ;
      S_I_CHK: begin
        if (r_row_cnt == r_height) w_next = S_FINISH;
        else if (r_occ < OCC_FULL) w_next = S_I_REQ;
      end
      S_I_REQ: begin
        w_rd_req  = 1'b1;
        w_rd_addr = r_row_addr + W_ADDR'(r_word_cnt);
        w_next    = S_I_WAIT;
      end
      S_I_WAIT: if (bus.i_rd_valid) w_next = w_i_last ? S_I_CHK : S_I_REQ;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filter_words  <= '0;
      r_filter_base   <= '0;
      r_height        <= '0;
      r_row_words     <= '0;
      r_row_addr      <= '0;
      r_word_cnt      <= '0;
      r_row_cnt       <= '0;
      r_wr_ptr        <= '0;
      r_occ           <= '0;
      r_buf_we        <= 1'b0;
      r_buf_is_filter <= 1'b0;
      r_buf_sel       <= '0;
      r_buf_addr      <= '0;
      r_buf_wdata     <= '0;
      r_fdone_pend    <= 1'b0;
      r_filter_done   <= 1'b0;
      r_idone_pend    <= '0;
      r_ifm_done      <= '0;
    end else begin
      r_buf_we      <= 1'b0;
      r_fdone_pend  <= 1'b0;
      r_idone_pend  <= '0;
      r_filter_done <= r_fdone_pend;
      r_ifm_done    <= r_idone_pend;
      // A release landing on a row completion cancels it; a release with nothing held is dropped.
      if (w_row_done && !i_row_release)
        r_occ <= r_occ + 1'b1;
      else if (!w_row_done && i_row_release && r_occ != '0)
        r_occ <= r_occ - 1'b1;
      case (r_state)
        S_IDLE: if (q_start) begin
          r_filter_words <= q_filter_words;
          r_filter_base  <= q_filter_base;
          r_height       <= q_height;
          r_row_words    <= w_row_words;
          r_row_addr     <= q_ifm_base;
          r_word_cnt     <= '0;
          r_row_cnt      <= '0;
          r_wr_ptr       <= '0;
          r_occ          <= '0;
        end
        S_F_WAIT: if (bus.i_rd_valid) begin
          r_buf_we        <= 1'b1;
          r_buf_is_filter <= 1'b1;
          r_buf_sel       <= '0;
          r_buf_addr      <= r_word_cnt;
          r_buf_wdata     <= bus.i_rd_data;
          r_word_cnt      <= w_f_last ? '0 : r_word_cnt + 1'b1;
          r_fdone_pend    <= w_f_last;
        end
        S_I_WAIT: if (bus.i_rd_valid) begin
          r_buf_we        <= 1'b1;
          r_buf_is_filter <= 1'b0;
          r_buf_sel       <= r_wr_ptr;
          r_buf_addr      <= r_word_cnt;
          r_buf_wdata     <= bus.i_rd_data;
          if (w_i_last) begin
            r_word_cnt   <= '0;
            r_row_cnt    <= r_row_cnt + 1'b1;
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_row_addr   <= r_row_addr + W_ADDR'(r_row_words);
            r_idone_pend <= IFM_BUF_CNT'(1) << r_wr_ptr;
          end else begin
            r_word_cnt   <= r_word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rd_req        = w_rd_req;
  assign bus.o_rd_addr       = w_rd_addr;
  assign bus.o_buf_we        = r_buf_we;
  assign bus.o_buf_is_filter = r_buf_is_filter;
  assign bus.o_buf_sel       = r_buf_sel;
  assign bus.o_buf_addr      = r_buf_addr;
  assign bus.o_buf_wdata     = r_buf_wdata;
  assign o_filter_buf_done   = r_filter_done;
  assign o_ifm_buf_done      = r_ifm_done;
  assign o_busy              = (r_state != S_IDLE);
endmodule

// File: tb/tb_cnn_buf_loader.sv
// Scoreboarded bench for cnn_buf_loader: expected requests, writes and done pulses are queued at start.
`timescale 1ns/1ps
module tb_cnn_buf_loader;
  typedef struct packed {
    logic        is_f;
    logic [1:0]  sel;
    logic [10:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_start;
  logic [9:0]  q_width, q_height;
  logic [4:0]  q_channel;
  logic [10:0] q_filter_words;
  logic [31:0] q_filter_base, q_ifm_base;
  logic        rel_mem, rel_auto, rel_man;
  logic        i_row_release;
  logic        o_filter_buf_done;
  logic [3:0]  o_ifm_buf_done;
  logic        o_busy;

  assign i_row_release = rel_mem | rel_auto | rel_man;

  always #5 clk = ~clk;

  cnn_buf_loader_if #(.W_ADDR(32), .W_DATA(64), .W_IFM_BUF(2), .W_BUF_ADDR(11)) bus();

  cnn_buf_loader dut (
    .clk(clk), .rst(rst), .q_start(q_start), .q_width(q_width), .q_height(q_height),
    .q_channel(q_channel), .q_filter_words(q_filter_words), .q_filter_base(q_filter_base),
    .q_ifm_base(q_ifm_base), .i_row_release(i_row_release), .bus(bus),
    .o_filter_buf_done(o_filter_buf_done), .o_ifm_buf_done(o_ifm_buf_done), .o_busy(o_busy)
  );

  int          n_chk = 0, n_fail = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_req[$];
  logic [4:0]  exp_done[$];
  int          cyc = 0, start_cyc = 0, fdone_cyc = 0, last_req_cyc = 0;
  int          done_cnt = 0, req_total = 0, req_n = 0, spacing_n = 0;
  bit          auto_rel = 0, m_rand = 0, spacing_chk = 0, rel_on_en = 0;
  logic [31:0] rel_on_addr = '0;

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h, required nothing", name, act);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: answers each request after 1 cycle plus an optional random extra delay.
  initial begin
    bit          m_pend;
    int          m_dly;
    logic [31:0] m_addr;
    m_pend = 0; m_dly = 0; m_addr = '0;
    bus.i_rd_valid = 1'b0; bus.i_rd_data = '0; rel_mem = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.i_rd_valid = 1'b0;
      rel_mem = 1'b0;
      if (rst) m_pend = 0;
      else if (m_pend) begin
        if (m_dly == 0) begin
          bus.i_rd_valid = 1'b1;
          bus.i_rd_data  = mem_data(m_addr);
          if (rel_on_en && m_addr == rel_on_addr) rel_mem = 1'b1;
          m_pend = 0;
        end else m_dly--;
      end
      if (!rst && bus.o_rd_req) begin
        m_pend = 1;
        m_addr = bus.o_rd_addr;
        m_dly  = m_rand ? int'($urandom_range(0, 5)) : 0;
      end
    end
  end

  initial begin
    rel_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      rel_auto = auto_rel && (o_ifm_buf_done != 4'b0);
    end
  end

  initial begin
    wr_t         e;
    logic [31:0] ea;
    logic [4:0]  ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_rd_req) begin
          req_total++;
          if (exp_req.size() == 0) unexpected("unexpected_rd_req", 64'(bus.o_rd_addr));
          else begin
            ea = exp_req.pop_front();
            check("rd_addr", 64'(bus.o_rd_addr), 64'(ea));
          end
          if (spacing_chk && req_n > 0 && req_n < spacing_n)
            check("req_spacing", 64'(cyc - last_req_cyc), 64'd2);
          last_req_cyc = cyc;
          req_n++;
        end
        if (bus.o_buf_we) begin
          if (exp_wr.size() == 0) unexpected("unexpected_buf_we", 64'(bus.o_buf_addr));
          else begin
            e = exp_wr.pop_front();
            check("wr_is_filter", 64'(bus.o_buf_is_filter), 64'(e.is_f));
            check("wr_addr", 64'(bus.o_buf_addr), 64'(e.addr));
            check("wr_data", bus.o_buf_wdata, e.data);
            if (!e.is_f) check("wr_sel", 64'(bus.o_buf_sel), 64'(e.sel));
          end
        end
        if (o_filter_buf_done || o_ifm_buf_done != 4'b0) begin
          if (o_ifm_buf_done != 4'b0) done_cnt++;
          if (o_filter_buf_done) fdone_cyc = cyc;
          if (exp_done.size() == 0) unexpected("unexpected_done", 64'({o_filter_buf_done, o_ifm_buf_done}));
          else begin
            ed = exp_done.pop_front();
            check("done_pulse", 64'({o_filter_buf_done, o_ifm_buf_done}), 64'(ed));
          end
        end
      end
    end
  end

  task automatic push_run(input int fw, input logic [31:0] fb, input int w, input int c,
                          input int h, input logic [31:0] ib);
    wr_t         e;
    logic [31:0] a;
    logic [3:0]  oh;
    int          rw;
    rw = w * c;
    for (int k = 0; k < fw; k++) begin
      a = fb + 32'(k);
      exp_req.push_back(a);
      e.is_f = 1'b1; e.sel = 2'd0; e.addr = 11'(k); e.data = mem_data(a);
      exp_wr.push_back(e);
    end
    exp_done.push_back(5'b10000);
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < rw; k++) begin
        a = ib + 32'(r * rw + k);
        exp_req.push_back(a);
        e.is_f = 1'b0; e.sel = 2'(r % 4); e.addr = 11'(k); e.data = mem_data(a);
        exp_wr.push_back(e);
      end
      oh = 4'b0001 << (r % 4);
      exp_done.push_back({1'b0, oh});
    end
  endtask

  task automatic start(input int fw, input logic [31:0] fb, input int w, input int c,
                       input int h, input logic [31:0] ib);
    @(posedge clk); #1;
    q_filter_words = 11'(fw); q_filter_base = fb; q_width = 10'(w); q_channel = 5'(c);
    q_height = 10'(h); q_ifm_base = ib;
    done_cnt = 0; req_n = 0;
    q_start = 1'b1;
    @(posedge clk); #1;
    q_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic pulse_release();
    rel_man = 1'b1;
    @(posedge clk); #1;
    rel_man = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (o_busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(o_busy), 64'd0);
    check({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    check({name, "_req_left"}, 64'(exp_req.size()), 64'd0);
    check({name, "_done_left"}, 64'(exp_done.size()), 64'd0);
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(done_cnt), 64'(target));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_rd_req"}, 64'(bus.o_rd_req), 64'd0);
    check({tag, "_rd_addr"}, 64'(bus.o_rd_addr), 64'd0);
    check({tag, "_buf_we"}, 64'(bus.o_buf_we), 64'd0);
    check({tag, "_is_filter"}, 64'(bus.o_buf_is_filter), 64'd0);
    check({tag, "_buf_sel"}, 64'(bus.o_buf_sel), 64'd0);
    check({tag, "_buf_addr"}, 64'(bus.o_buf_addr), 64'd0);
    check({tag, "_buf_wdata"}, bus.o_buf_wdata, 64'd0);
    check({tag, "_filter_done"}, 64'(o_filter_buf_done), 64'd0);
    check({tag, "_ifm_done"}, 64'(o_ifm_buf_done), 64'd0);
  endtask

  initial begin
    int r0;
    rst = 1'b1; q_start = 1'b0; rel_man = 1'b0;
    q_width = '0; q_height = '0; q_channel = '0; q_filter_words = '0;
    q_filter_base = '0; q_ifm_base = '0;
    @(posedge clk); #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Filter load timing, then a 6-row ring with immediate releases and a stray release at occ=0.
    auto_rel = 1; spacing_chk = 1; spacing_n = 64;
    push_run(64, 32'h0000_1000, 256, 4, 6, 32'h0002_0000);
    start(64, 32'h0000_1000, 256, 4, 6, 32'h0002_0000);
    repeat (10) @(posedge clk);
    #1 pulse_release();
    wait_idle(20000, "ring_busy_fall");
    check("filter_done_latency", 64'(fdone_cyc - start_cyc), 64'd129);
    spacing_chk = 0;

    // Backpressure: four rows fill the ring, then one release lets row 4 go.
    auto_rel = 0;
    push_run(4, 32'h0000_0500, 8, 2, 6, 32'h0000_8000);
    start(4, 32'h0000_0500, 8, 2, 6, 32'h0000_8000);
    wait_dones(4, 2000, "bp_four_rows");
    repeat (4) @(posedge clk);
    #1 r0 = req_total;
    repeat (50) @(posedge clk);
    #1 check("bp_stall_no_req", 64'(req_total - r0), 64'd0);
    check("bp_stall_done_cnt", 64'(done_cnt), 64'd4);
    pulse_release();
    @(negedge clk); #1;
    check("bp_req_not_yet", 64'(bus.o_rd_req), 64'd0);
    @(negedge clk); #1;
    check("bp_req_two_after", 64'(bus.o_rd_req), 64'd1);
    auto_rel = 1;
    wait_idle(2000, "bp_busy_fall");

    // Release coinciding with the row-3 completion keeps occ at 3: exactly one more row, then stall.
    auto_rel = 0;
    rel_on_addr = 32'h0000_0300 + 32'd7; rel_on_en = 1;
    push_run(2, 32'h0000_0040, 2, 1, 6, 32'h0000_0300);
    start(2, 32'h0000_0040, 2, 1, 6, 32'h0000_0300);
    pulse_release();
    wait_dones(5, 500, "sim_five_rows");
    #1 r0 = req_total;
    repeat (30) @(posedge clk);
    #1 check("sim_stall_no_req", 64'(req_total - r0), 64'd0);
    check("sim_stall_done_cnt", 64'(done_cnt), 64'd5);
    rel_on_en = 0;
    pulse_release();
    wait_idle(500, "sim_busy_fall");

    // Reset during row 2, then a fresh start from the filter base.
    auto_rel = 1;
    push_run(3, 32'h0000_7000, 4, 2, 4, 32'h0000_9000);
    start(3, 32'h0000_7000, 4, 2, 4, 32'h0000_9000);
    wait_dones(2, 500, "rst_two_rows");
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    exp_wr.delete(); exp_req.delete(); exp_done.delete();
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_stays_idle", 64'(o_busy), 64'd0);
    push_run(3, 32'h0000_7000, 4, 2, 4, 32'h0000_9000);
    start(3, 32'h0000_7000, 4, 2, 4, 32'h0000_9000);
    wait_idle(1000, "rst_restart_busy_fall");

    // Random read latency with addresses wrapping past 2^32.
    m_rand = 1;
    push_run(5, 32'hFFFF_FFFE, 3, 3, 5, 32'hFFFF_FFF0);
    start(5, 32'hFFFF_FFFE, 3, 3, 5, 32'hFFFF_FFF0);
    wait_idle(5000, "varlat_busy_fall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cnn_buf_loader.md
# cnn_buf_loader

Fetch engine that fills the on-chip filter buffer and the ring of IFM row buffers from external memory, and emits the per-buffer done pulses that `cnn_ctrl` consumes as `q_filter_buf_done` and `q_ifm_buf_done`. On start it loads one filter tile, then streams IFM rows round-robin into `IFM_BUF_CNT` row buffers. It stalls whenever every row buffer holds a row that the compute side has not yet released.

## Interface
- `W_SIZE`, 10: width/height field width.
- `W_CHANNEL`, 5: tiled-channel field width.
- `IFM_BUF_CNT`, 4: number of IFM row buffers; must be a power of two.
- `W_IFM_BUF`, 2: log2(IFM_BUF_CNT).
- `W_ADDR`, 32: external word address width.
- `W_DATA`, 64: data word width.
- `W_BUF_ADDR`, 11: buffer-local word address width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `q_start` in 1: start pulse; sampled only in IDLE.
- `q_width` in W_SIZE: IFM width in pixels.
- `q_height` in W_SIZE: IFM height in rows.
- `q_channel` in W_CHANNEL: tiled input channels; words per pixel.
- `q_filter_words` in W_BUF_ADDR: filter tile size in words.
- `q_filter_base` in W_ADDR: external address of filter word 0.
- `q_ifm_base` in W_ADDR: external address of IFM word 0.
- `i_row_release` in 1: pulse; the compute side frees the oldest filled row buffer.
- `o_rd_req` out 1: one-cycle read request.
- `o_rd_addr` out W_ADDR: read address; valid while `o_rd_req`=1.
- `i_rd_valid` in 1: read data returned.
- `i_rd_data` in W_DATA: read data.
- `o_buf_we` out 1: buffer write strobe.
- `o_buf_is_filter` out 1: 1 selects the filter buffer, 0 selects the IFM buffer.
- `o_buf_sel` out W_IFM_BUF: target IFM buffer index.
- `o_buf_addr` out W_BUF_ADDR: buffer-local word address.
- `o_buf_wdata` out W_DATA: write data.
- `o_filter_buf_done` out 1: one-cycle pulse when the filter tile is complete.
- `o_ifm_buf_done` out IFM_BUF_CNT: one-hot one-cycle pulse when row buffer k is complete.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, F_REQ, F_WAIT, I_CHK, I_REQ, I_WAIT, FINISH.
- **IDLE**
  - On `q_start`=1: latch all `q_*` inputs.
  - Compute row_words = q_width*q_channel, zero-extended to W_BUF_ADDR.
  - Clear word_cnt, row_cnt, wr_ptr and occ, then go to F_REQ.
- **F_REQ**
  - Assert `o_rd_req` with `o_rd_addr`=filter_base+word_cnt, then go to F_WAIT.
- **F_WAIT**
  - On `i_rd_valid`: register a write to the filter buffer at address word_cnt and increment word_cnt.
  - If this was the last word (word_cnt = q_filter_words-1), clear word_cnt and go to I_CHK.
  - Otherwise go to F_REQ.
- **I_CHK**
  - If row_cnt = q_height, go to FINISH.
  - Else if occ < IFM_BUF_CNT, go to I_REQ.
  - Otherwise stay in I_CHK.
- **I_REQ**
  - Assert `o_rd_req` with `o_rd_addr`=ifm_base+row_cnt*row_words+word_cnt, then go to I_WAIT.
- **I_WAIT**
  - On `i_rd_valid`: register a write to buffer wr_ptr at address word_cnt.
  - On the last word of the row: increment row_cnt, increment wr_ptr (mod IFM_BUF_CNT), increment occ, clear word_cnt, and go to I_CHK.
  - Otherwise go to I_REQ.
- **FINISH**
  - Go to IDLE after one cycle.
  - `occ` keeps tracking releases while in IDLE.
- Occupancy update rules:
  - Row completion and `i_row_release` in the same cycle: occ is unchanged.
  - Release while occ=0: ignored.
- Zero-size cases:
  - q_filter_words=0 is illegal.
  - q_height=0: after the filter load, go through I_CHK straight to FINISH.
- `q_start` while busy is ignored.
- `rst` asserted mid-operation returns to IDLE immediately; all counters and outputs are cleared and no done pulse is emitted.
- External addresses are computed modulo 2^W_ADDR.

## Timing
- Reset values: all outputs are 0, including `o_busy`.
- Per-word sequence:
  - `o_rd_req` at cycle t.
  - `i_rd_valid` at t+1 or later.
  - `o_buf_we` is registered one cycle after `i_rd_valid`; it coincides with the next `o_rd_req` if any.
  - Peak rate is 1 word per 2 cycles.
- Exactly one read is outstanding at a time; `i_rd_valid` outside F_WAIT/I_WAIT is ignored.
- `o_filter_buf_done` pulses the cycle after the last filter `o_buf_we`.
- `o_ifm_buf_done[k]` pulses the cycle after the last `o_buf_we` of a row written to buffer k; exactly one bit is set.
- Start latency: first `o_rd_req` follows 1 cycle after `q_start` is sampled.
- A stall ends one cycle after the releasing `i_row_release`: I_CHK sees the decremented occ, then I_REQ follows.
- `o_busy` falls the cycle after FINISH.

## Test plan
- **Filter load:** filter_words=64, memory with 1-cycle latency → 64 requests at 2-cycle spacing, addresses base..base+63; `o_filter_buf_done` pulses once, 129 cycles after start.
- **Row ring:** width=256, channel=4, height=6, compute side releases each row as soon as it is done → `o_ifm_buf_done` sequence 0001, 0010, 0100, 1000, 0001, 0010; each row is 1024 writes with addresses 0..1023.
- **Backpressure:** height=6, no releases → after 4 rows the loader stays in I_CHK with no `o_rd_req`. One `i_row_release` → row 4 request issues 2 cycles later into buffer 0.
- **Simultaneous events:** release coinciding with a row completion at occ=3 → occ stays 3; a release at occ=0 is ignored and occ stays 0.
- **Reset mid-row:** `rst` asserted during row 2 → all outputs 0 asynchronously. A fresh `q_start` restarts from the filter at filter_base.
- **Variable latency:** `i_rd_valid` delayed 0–5 random cycles → write data and addresses match the memory model exactly, with no skipped or duplicated words.
